icp_scatter: RTL and testbench

- Inverse of the channel-reduction stage: takes a serial stream of input-channel activations, one word per cycle, and assembles groups of ICP_NUM words.
- Each group is presented in parallel to the ICP_NUM PE lanes, tagged with a PE_STATE status.
- Sits between the activation buffer read port and the PE array input.
- Holds one group under assembly and one group registered on the output (two-deep buffering), so upstream streams without bubbles while the PE array accepts a group every ICP_NUM cycles.

---
 rtl/icp_scatter_pkg.sv | 22 ++
 rtl/icp_scatter_if.sv | 27 ++
 rtl/icp_lane_reg.sv | 22 ++
 rtl/icp_scatter.sv | 134 +++++++++++++
 tb/tb_icp_scatter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/icp_scatter_pkg.sv
// Shared CNN types for the channel scatter stage: PE lane status, scatter FSM
// state and the default word width / lane count defines.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ICP_NUM
`define ICP_NUM 4
`endif

package icp_scatter_pkg;

  typedef enum logic {
    INVALID = 1'b0,
    VALID   = 1'b1
  } pe_state_e;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } scat_state_e;

endpackage

// File: rtl/icp_scatter_if.sv
// Stream-in / lane-vector-out bundle between the activation buffer, the
// scatter stage and the PE array.
interface icp_scatter_if #(
  parameter int unsigned DATA_WID = `CNN_XLEN,
  parameter int unsigned ICP_NUM  = `ICP_NUM
) ();
  import icp_scatter_pkg::*;

  logic                       in_valid;
  logic signed [DATA_WID-1:0] in_data;
  logic                       in_last;
  logic                       in_ready;
  logic                       out_ready;
  pe_state_e                  status_out;
  logic signed [DATA_WID-1:0] data_out [ICP_NUM-1:0];

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, status_out, data_out
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, status_out, data_out
  );

endinterface

// File: rtl/icp_lane_reg.sv
// One lane of the scatter assembly register: loads on write-enable, clears to
// zero when its group leaves so unfilled lanes of the next group read as padding.
module icp_lane_reg #(
  parameter int unsigned DATA_WID = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic                       clr,
  input  logic signed [DATA_WID-1:0] d,
  output logic signed [DATA_WID-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/icp_scatter.sv
// Serial-to-parallel channel scatter: packs ICP_NUM activation words into a
// lane vector for the PE array. Define ICP_SCATTER_PERF_EN for the stall_cnt port.
module icp_scatter
  import icp_scatter_pkg::*;
#(
  parameter int unsigned DATA_WID = `CNN_XLEN,
  parameter int unsigned ICP_NUM  = `ICP_NUM
) (
  input  logic          clk,
  input  logic          reset,
  icp_scatter_if.slave  bus
`ifdef ICP_SCATTER_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int unsigned CNT_W = (ICP_NUM > 1) ? $clog2(ICP_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(ICP_NUM - 1);

  scat_state_e                state, state_nxt;
  logic        [CNT_W-1:0]    cnt;
  pe_state_e                  status_q;
  logic signed [DATA_WID-1:0] data_q  [ICP_NUM-1:0];
  logic signed [DATA_WID-1:0] asm_q   [ICP_NUM-1:0];
  logic signed [DATA_WID-1:0] group_c [ICP_NUM-1:0];
  logic        [ICP_NUM-1:0]  lane_we_c;

  logic in_ready_c, accept_c, close_c, slot_free_c;
  logic load_out_c, from_asm_c, clr_asm_c;

  assign in_ready_c     = (state == FILL);
  assign bus.in_ready   = in_ready_c;
  assign bus.status_out = status_q;
  assign bus.data_out   = data_q;

  assign accept_c    = bus.in_valid && in_ready_c;
  assign close_c     = accept_c && (bus.in_last || (cnt == LAST_LANE));
  assign slot_free_c = (status_q == INVALID) || bus.out_ready;

  // Group as it would look after this cycle's word lands; lanes past it are zero.
  always_comb begin
    for (int k = 0; k < int'(ICP_NUM); k++) begin
      lane_we_c[k] = accept_c && (cnt == CNT_W'(k));
      if (lane_we_c[k]) begin
        group_c[k] = bus.in_data;
      end else if (CNT_W'(k) > cnt) begin
        group_c[k] = '0;
      end else begin
        group_c[k] = asm_q[k];
      end
    end
  end

  for (genvar g = 0; g < int'(ICP_NUM); g++) begin : g_lane
    icp_lane_reg #(.DATA_WID(DATA_WID)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (lane_we_c[g]),
      .clr   (clr_asm_c),
      .d     (bus.in_data),
      .q     (asm_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and transfer control between assembly register and output slot.
  always_comb begin
    state_nxt  = state;
    load_out_c = 1'b0;
    from_asm_c = 1'b0;
    clr_asm_c  = 1'b0;
    case (state)
      FILL: begin
        if (close_c) begin
          if (slot_free_c) begin
            load_out_c = 1'b1;
            clr_asm_c  = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          load_out_c = 1'b1;
          from_asm_c = 1'b1;
          clr_asm_c  = 1'b1;
          state_nxt  = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      status_q <= INVALID;
      for (int k = 0; k < int'(ICP_NUM); k++) data_q[k] <= '0;
    end else begin
      if (accept_c) begin
        cnt <= close_c ? '0 : cnt + CNT_W'(1);
      end
      if (load_out_c) begin
        status_q <= VALID;
        for (int k = 0; k < int'(ICP_NUM); k++) begin
          data_q[k] <= from_asm_c ? asm_q[k] : group_c[k];
        end
      end else if ((status_q == VALID) && bus.out_ready) begin
        status_q <= INVALID;
      end
    end
  end

`ifdef ICP_SCATTER_PERF_EN
  // Upstream cycles lost to a full assembly register; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !in_ready_c && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icp_scatter.sv
// Scoreboard bench for icp_scatter at DATA_WID=16, ICP_NUM=4: expected groups are
// queued as words are issued and a negedge monitor checks every consumed group.
`timescale 1ns/1ps
module tb_icp_scatter;
  import icp_scatter_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NL = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [63:0] exp_q[$];

  icp_scatter_if #(.DATA_WID(DW), .ICP_NUM(NL)) bus ();

`ifdef ICP_SCATTER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  icp_scatter #(.DATA_WID(DW), .ICP_NUM(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ICP_SCATTER_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [63:0] got_vec();
    return {bus.data_out[3], bus.data_out[2], bus.data_out[1], bus.data_out[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns once it has been accepted (cycles taken in n).
  task automatic send(input int d, input logic last, output int n);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(d);
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
    end
    tick();
    n++;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Monitor: each group the PE array consumes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.status_out == VALID && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_group: got %h, required no group", got_vec());
      end else begin
        chk("group", got_vec(), exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int total;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'sd5;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held two cycles with in_valid high.
    tick();
    tick();
    chk("rst_status", 64'(bus.status_out), 64'(INVALID));
    chk("rst_data",   got_vec(), 64'd0);
    chk("rst_ready",  64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Full group with sign preserved.
    send(1, 1'b0, n); send(-2, 1'b0, n); send(3, 1'b0, n);
    exp_q.push_back(pk(1, -2, 3, -4));
    send(-4, 1'b0, n);
    tick(); tick();

    // Partial group closed by in_last, then a full group starting at lane 0.
    send(7, 1'b0, n);
    exp_q.push_back(pk(7, 8, 0, 0));
    send(8, 1'b1, n);
    send(9, 1'b0, n); send(10, 1'b0, n); send(11, 1'b0, n);
    exp_q.push_back(pk(9, 10, 11, 12));
    send(12, 1'b0, n);
    // in_last on lane 0 gives a one-word group.
    exp_q.push_back(pk(5, 0, 0, 0));
    send(5, 1'b1, n);
    tick(); tick();

    // Back-to-back 12 words with the PE array always ready.
    total = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) exp_q.push_back(pk(i - 3 + 20, i - 2 + 20, i - 1 + 20, i + 20));
      send(i + 20, 1'b0, n);
      total += n;
    end
    chk("b2b_cycles", 64'(total), 64'd12);
    tick(); tick();

    // Close and consume in the same cycle: new group replaces old with no gap.
    bus.out_ready = 1'b0;
    exp_q.push_back(pk(-100, -101, -102, -103));
    for (int i = 0; i < 4; i++) send(-100 - i, 1'b0, n);
    for (int i = 0; i < 3; i++) send(40 + i, 1'b0, n);
    exp_q.push_back(pk(40, 41, 42, 43));
    bus.out_ready = 1'b1;
    send(43, 1'b0, n);
    chk("nogap_status", 64'(bus.status_out), 64'(VALID));
    tick(); tick();

    // Backpressure: one group held on output, second fills assembly.
    bus.out_ready = 1'b0;
    exp_q.push_back(pk(50, 51, 52, 53));
    exp_q.push_back(pk(60, 61, 62, 63));
    for (int i = 0; i < 4; i++) send(50 + i, 1'b0, n);
    for (int i = 0; i < 4; i++) send(60 + i, 1'b0, n);
    chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd99;
    tick(); tick(); tick();
    bus.in_valid = 1'b0;
    chk("bp_still_held", 64'(bus.in_ready), 64'd0);
`ifdef ICP_SCATTER_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release_status", 64'(bus.status_out), 64'(VALID));
    chk("bp_release_ready",  64'(bus.in_ready), 64'd1);
    tick();
    bus.out_ready = 1'b1;
    tick(); tick();

    // Reset with both slots full: held groups must never appear.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(70 + i, 1'b0, n);
    chk("hold_ready_low", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hold_rst_status", 64'(bus.status_out), 64'(INVALID));
    chk("hold_rst_ready",  64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exp_q.push_back(pk(-9, 0, 0, 0));
    send(-9, 1'b1, n);

    // Drain with a bounded wait, then confirm every expected group was seen.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
